// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing sequencer: opcodes, condition codes,
// FSM states, instruction field positions and opcode class helpers.
package dp_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COND,
        ST_RD_RS,
        ST_RD_OP,
        ST_EXEC,
        ST_WB
    } state_t;

    localparam int COND_HI_POS = 31;
    localparam int COND_LO_POS = 28;
    localparam int I_POS       = 25;
    localparam int OPC_HI_POS  = 24;
    localparam int OPC_LO_POS  = 21;
    localparam int S_POS       = 20;
    localparam int RN_HI_POS   = 19;
    localparam int RN_LO_POS   = 16;
    localparam int RD_HI_POS   = 15;
    localparam int RD_LO_POS   = 12;
    localparam int OP2_HI_POS  = 11;
    localparam int RSHIFT_POS  = 4;

    function automatic logic is_arith(input logic [3:0] op);
        case (op)
            OP_SUB, OP_RSB, OP_ADD, OP_ADC,
            OP_SBC, OP_RSC, OP_CMP, OP_CMN: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_compare(input logic [3:0] op);
        case (op)
            OP_TST, OP_TEQ, OP_CMP, OP_CMN: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code check against NZCV; NV always fails.
module cond_eval
    import dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer: runs one data-processing instruction through the shared
// ALU and register file, and owns the architectural NZCV flags.
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int REG_SIZE  = 32,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    output logic [ADDR_SIZE-1:0] rf_raddr0,
    output logic [ADDR_SIZE-1:0] rf_raddr1,
    input  logic [REG_SIZE-1:0]  rf_rdata0,
    input  logic [REG_SIZE-1:0]  rf_rdata1,
    output logic [3:0]           alu_opcode,
    output logic [REG_SIZE-1:0]  alu_d0,
    output logic [REG_SIZE-1:0]  alu_d1,
    output logic [7:0]           alu_imm,
    output logic [7:0]           alu_shift,
    output logic [3:0]           alu_rot,
    output logic [3:0]           alu_shift_byte,
    output logic                 alu_b_imm,
    output logic                 alu_cin,
    input  logic [REG_SIZE-1:0]  alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_overflow,
    input  logic                 alu_we,
    output logic                 rf_we,
    output logic [ADDR_SIZE-1:0] rf_waddr,
    output logic [REG_SIZE-1:0]  rf_wdata,
    output logic [3:0]           flags,
    output logic                 done,
    output logic                 skipped
);

    state_t      state;
    logic [31:0] instr_q;
    logic        skip_q;
    logic [3:0]  rs_amt;
    logic        carry_q;
    logic        ovf_q;

    logic [3:0]  f_cond, f_opc, f_rn, f_rd, f_rs, f_rm;
    logic        f_i, f_s, f_rshift;
    logic [11:0] f_op2;
    logic        cond_pass;
    logic        flag_upd;
    logic        unused_instr_bits;

    assign f_cond   = instr_q[COND_HI_POS:COND_LO_POS];
    assign f_i      = instr_q[I_POS];
    assign f_opc    = instr_q[OPC_HI_POS:OPC_LO_POS];
    assign f_s      = instr_q[S_POS];
    assign f_rn     = instr_q[RN_HI_POS:RN_LO_POS];
    assign f_rd     = instr_q[RD_HI_POS:RD_LO_POS];
    assign f_op2    = instr_q[OP2_HI_POS:0];
    assign f_rs     = f_op2[11:8];
    assign f_rm     = f_op2[3:0];
    assign f_rshift = ~f_i & f_op2[RSHIFT_POS];
    assign flag_upd = f_s | is_compare(f_opc);
    assign unused_instr_bits = ^instr_q[27:26];

    // The ALU keeps no carry state; the architectural C flag is its carry input.
    assign alu_cin = flags[1];

    cond_eval u_cond_eval (
        .cond (f_cond),
        .nzcv (flags),
        .pass (cond_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            instr_q        <= '0;
            skip_q         <= 1'b0;
            rs_amt         <= '0;
            carry_q        <= 1'b0;
            ovf_q          <= 1'b0;
            in_ready       <= 1'b1;
            rf_raddr0      <= '0;
            rf_raddr1      <= '0;
            alu_opcode     <= '0;
            alu_d0         <= '0;
            alu_d1         <= '0;
            alu_imm        <= '0;
            alu_shift      <= '0;
            alu_rot        <= '0;
            alu_shift_byte <= '0;
            alu_b_imm      <= 1'b0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            flags          <= '0;
            done           <= 1'b0;
            skipped        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        instr_q  <= instr;
                        in_ready <= 1'b0;
                        state    <= ST_COND;
                    end
                end
                ST_COND: begin
                    if (!cond_pass) begin
                        skip_q  <= 1'b1;
                        done    <= 1'b1;
                        skipped <= 1'b1;
                        state   <= ST_WB;
                    end else if (f_rshift) begin
                        skip_q    <= 1'b0;
                        rf_raddr1 <= ADDR_SIZE'(f_rs);
                        state     <= ST_RD_RS;
                    end else begin
                        skip_q    <= 1'b0;
                        rf_raddr0 <= ADDR_SIZE'(f_rn);
                        rf_raddr1 <= ADDR_SIZE'(f_rm);
                        state     <= ST_RD_OP;
                    end
                end
                ST_RD_RS: begin
                    rs_amt    <= rf_rdata1[3:0];
                    rf_raddr0 <= ADDR_SIZE'(f_rn);
                    rf_raddr1 <= ADDR_SIZE'(f_rm);
                    state     <= ST_RD_OP;
                end
                // Operands and control fields are registered here so they hold for all of EXEC.
                ST_RD_OP: begin
                    alu_d0         <= rf_rdata0;
                    alu_d1         <= rf_rdata1;
                    alu_opcode     <= f_opc;
                    alu_imm        <= f_op2[7:0];
                    alu_rot        <= f_op2[11:8];
                    alu_b_imm      <= f_i;
                    alu_shift      <= {f_op2[11:5], f_op2[RSHIFT_POS]};
                    alu_shift_byte <= f_rshift ? rs_amt : 4'd0;
                    state          <= ST_EXEC;
                end
                ST_EXEC: begin
                    rf_we    <= alu_we;
                    rf_waddr <= ADDR_SIZE'(f_rd);
                    rf_wdata <= alu_result;
                    carry_q  <= alu_carry;
                    ovf_q    <= alu_overflow;
                    done     <= 1'b1;
                    skipped  <= 1'b0;
                    state    <= ST_WB;
                end
                // Logical ops leave C and V alone; compares update flags even without S.
                ST_WB: begin
                    if (!skip_q && flag_upd) begin
                        flags <= {rf_wdata[REG_SIZE-1],
                                  (rf_wdata == '0),
                                  is_arith(f_opc) ? carry_q : flags[1],
                                  is_arith(f_opc) ? ovf_q   : flags[0]};
                    end
                    rf_we    <= 1'b0;
                    done     <= 1'b0;
                    skipped  <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: directed table, reset corner cases and random
// instructions checked against an architectural model of the instruction set.
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [3:0]  rf_raddr0, rf_raddr1;
    logic [31:0] rf_rdata0, rf_rdata1;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_d0, alu_d1;
    logic [7:0]  alu_imm, alu_shift;
    logic [3:0]  alu_rot, alu_shift_byte;
    logic        alu_b_imm, alu_cin;
    logic [31:0] alu_result;
    logic        alu_carry, alu_overflow, alu_we;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  flags;
    logic        done, skipped;

    always #5 clk = ~clk;

    dp_sequencer #(.REG_SIZE(32), .ADDR_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .alu_opcode(alu_opcode), .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_imm(alu_imm),
        .alu_shift(alu_shift), .alu_rot(alu_rot), .alu_shift_byte(alu_shift_byte),
        .alu_b_imm(alu_b_imm), .alu_cin(alu_cin), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_we(alu_we),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flags(flags),
        .done(done), .skipped(skipped)
    );

    // Register file (asynchronous read) and architectural model state
    logic [31:0] rf    [16];
    logic [31:0] mregs [16];
    logic [3:0]  mflags;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign rf_rdata0 = rf[rf_raddr0];
    assign rf_rdata1 = rf[rf_raddr1];

    typedef struct {
        int          lat;
        logic        skip;
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  flags;
        logic [3:0]  sbyte;
        logic        cin;
        logic        rdy;
    } res_t;

    typedef struct {
        logic [31:0] ins;
        int          lat;
        logic        skip;
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  flags;
        logic [3:0]  sbyte;
        logic        cin;
    } vec_t;

    function automatic logic [31:0] enc(input logic [3:0] c, input logic i, input logic [3:0] op,
                                        input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] op2);
        return {c, 2'b00, i, op, s, rn, rd, op2};
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x >> k) | (x << (32 - k));
    endfunction

    // {V, C, result}
    function automatic logic [33:0] add3(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y} + {32'd0, c};
        return {(x[31] == y[31]) && (s[31] != x[31]), s[32], s[31:0]};
    endfunction

    function automatic logic [33:0] arm_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        case (op)
            4'd0, 4'd8:  return {2'b00, a & b};
            4'd1, 4'd9:  return {2'b00, a ^ b};
            4'd2, 4'd10: return add3(a, ~b, 1'b1);
            4'd3:        return add3(b, ~a, 1'b1);
            4'd4, 4'd11: return add3(a, b, 1'b0);
            4'd5:        return add3(a, b, cin);
            4'd6:        return add3(a, ~b, cin);
            4'd7:        return add3(b, ~a, cin);
            4'd12:       return {2'b00, a | b};
            4'd13:       return {2'b00, b};
            4'd14:       return {2'b00, a & ~b};
            default:     return {2'b00, ~b};
        endcase
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural ALU answering the sequencer's control fields
    logic [31:0] alu_b;
    logic [33:0] alu_out;
    int          shamt;
    always_comb begin
        shamt        = alu_shift[0] ? int'(alu_shift_byte) : int'(alu_shift[7:3]);
        alu_b        = alu_b_imm ? ror32({24'd0, alu_imm}, 2 * int'(alu_rot)) : (alu_d1 << shamt);
        alu_out      = arm_alu(alu_opcode, alu_d0, alu_b, alu_cin);
        alu_result   = alu_out[31:0];
        alu_carry    = alu_out[32];
        alu_overflow = alu_out[33];
        alu_we       = (alu_opcode[3:2] != 2'b10);
    end

    // Architectural reference: one whole instruction at a time
    function automatic res_t ref_exec(input logic [31:0] ins);
        res_t        e;
        logic [3:0]  op, rn, rd;
        logic [11:0] op2;
        logic        i, s, regshift, arith, cmp;
        int          amt;
        logic [31:0] b;
        logic [33:0] r;
        e = '{default: '0};
        e.rdy = 1'b1;
        e.cin = mflags[1];
        if (!cond_ok(ins[31:28], mflags)) begin
            e.skip  = 1'b1;
            e.lat   = 2;
            e.flags = mflags;
            return e;
        end
        i = ins[25]; op = ins[24:21]; s = ins[20]; rn = ins[19:16]; rd = ins[15:12]; op2 = ins[11:0];
        regshift = !i && op2[4];
        amt      = regshift ? int'(mregs[op2[11:8]][3:0]) : int'(op2[11:7]);
        b        = i ? ror32({24'd0, op2[7:0]}, 2 * int'(op2[11:8])) : (mregs[op2[3:0]] << amt);
        r        = arm_alu(op, mregs[rn], b, mflags[1]);
        cmp      = (op >= 4'd8) && (op <= 4'd11);
        arith    = ((op >= 4'd2) && (op <= 4'd7)) || op == 4'd10 || op == 4'd11;
        e.lat    = regshift ? 5 : 4;
        e.sbyte  = regshift ? 4'(amt) : 4'd0;
        e.we     = !cmp;
        e.waddr  = rd;
        e.wdata  = r[31:0];
        if (s || cmp)
            mflags = {r[31], r[31:0] == 32'd0, arith ? r[32] : mflags[1], arith ? r[33] : mflags[0]};
        if (e.we) mregs[rd] = r[31:0];
        e.flags = mflags;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input bit hold, output res_t a, output bit ok);
        int n;
        a  = '{default: '0};
        ok = 1'b0;
        n  = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_wait: in_ready=0 after %0d cycles, required 1", n);
            return;
        end
        instr    = ins;
        in_valid = 1'b1;
        @(posedge clk);
        while (a.lat < 20) begin
            @(negedge clk);
            a.lat++;
            if (hold) instr = $urandom(); else in_valid = 1'b0;
            if (done) break;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_wait: no done within %0d cycles of accept", a.lat);
            return;
        end
        a.skip  = skipped;
        a.we    = rf_we;
        a.waddr = rf_waddr;
        a.wdata = rf_wdata;
        a.sbyte = alu_shift_byte;
        a.cin   = alu_cin;
        if (rf_we) rf[rf_waddr] = rf_wdata;
        @(negedge clk);
        a.flags = flags;
        a.rdy   = in_ready;
        ok      = 1'b1;
    endtask

    task automatic compare(input string tag, input res_t a, input res_t e);
        chk({tag, ".latency"}, 32'(a.lat), 32'(e.lat));
        chk({tag, ".skipped"}, 32'(a.skip), 32'(e.skip));
        chk({tag, ".rf_we"}, 32'(a.we), 32'(e.we));
        if (e.we) begin
            chk({tag, ".rf_waddr"}, 32'(a.waddr), 32'(e.waddr));
            chk({tag, ".rf_wdata"}, a.wdata, e.wdata);
        end
        if (!e.skip) chk({tag, ".shift_byte"}, 32'(a.sbyte), 32'(e.sbyte));
        chk({tag, ".alu_cin"}, 32'(a.cin), 32'(e.cin));
        chk({tag, ".flags"}, 32'(a.flags), 32'(e.flags));
        chk({tag, ".in_ready"}, 32'(a.rdy), 32'(e.rdy));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [11];
        res_t        a, e;
        bit          ok, saw;
        logic [31:0] ins, v;
        logic [11:0] op2;
        logic [3:0]  c;
        logic        i;

        tbl[0]  = '{enc(4'hE, 1'b0, 4'd4,  1'b1, 4'd2,  4'd1,  12'h003), 4, 1'b0, 1'b1, 4'd1,  32'd12,        4'b0000, 4'd0, 1'b0};
        tbl[1]  = '{enc(4'hE, 1'b0, 4'd10, 1'b0, 4'd0,  4'd0,  12'h000), 4, 1'b0, 1'b0, 4'd0,  32'd0,         4'b0110, 4'd0, 1'b0};
        tbl[2]  = '{enc(4'h0, 1'b1, 4'd4,  1'b0, 4'd4,  4'd4,  12'h001), 4, 1'b0, 1'b1, 4'd4,  32'd11,        4'b0110, 4'd0, 1'b1};
        tbl[3]  = '{enc(4'h1, 1'b0, 4'd4,  1'b0, 4'd4,  4'd5,  12'h004), 2, 1'b1, 1'b0, 4'd0,  32'd0,         4'b0110, 4'd0, 1'b1};
        tbl[4]  = '{enc(4'hE, 1'b0, 4'd5,  1'b1, 4'd8,  4'd10, 12'h009), 4, 1'b0, 1'b1, 4'd10, 32'd0,         4'b0110, 4'd0, 1'b1};
        tbl[5]  = '{enc(4'hE, 1'b0, 4'd13, 1'b0, 4'd0,  4'd5,  12'h716), 5, 1'b0, 1'b1, 4'd5,  32'd8,         4'b0110, 4'd3, 1'b1};
        tbl[6]  = '{enc(4'hF, 1'b0, 4'd4,  1'b1, 4'd2,  4'd1,  12'h003), 2, 1'b1, 1'b0, 4'd0,  32'd0,         4'b0110, 4'd0, 1'b1};
        tbl[7]  = '{enc(4'hE, 1'b0, 4'd2,  1'b1, 4'd2,  4'd11, 12'h003), 4, 1'b0, 1'b1, 4'd11, 32'hFFFFFFFE,  4'b1000, 4'd0, 1'b1};
        tbl[8]  = '{enc(4'hE, 1'b0, 4'd12, 1'b0, 4'd2,  4'd13, 12'h203), 4, 1'b0, 1'b1, 4'd13, 32'h00000075,  4'b1000, 4'd0, 1'b0};
        tbl[9]  = '{enc(4'hE, 1'b1, 4'd4,  1'b1, 4'd12, 4'd14, 12'h001), 4, 1'b0, 1'b1, 4'd14, 32'h80000000,  4'b1001, 4'd0, 1'b0};
        tbl[10] = '{enc(4'hE, 1'b1, 4'd13, 1'b0, 4'd0,  4'd15, 12'h4AB), 4, 1'b0, 1'b1, 4'd15, 32'hAB000000,  4'b1001, 4'd0, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        for (int k = 0; k < 16; k++) rf[k] = 32'd0;
        rf[2] = 32'd5;  rf[3] = 32'd7;  rf[4] = 32'd10; rf[6] = 32'd1;
        rf[7] = 32'd3;  rf[8] = 32'hFFFFFFFF; rf[12] = 32'h7FFFFFFF;
        for (int k = 0; k < 16; k++) mregs[k] = rf[k];
        mflags = 4'd0;

        repeat (3) @(negedge clk);
        chk("reset.flags", 32'(flags), 32'd0);
        chk("reset.rf_we", 32'(rf_we), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.skipped", 32'(skipped), 32'd0);
        chk("reset.alu_d0", alu_d0, 32'd0);
        chk("reset.alu_opcode", 32'(alu_opcode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 11; k++) begin
            e = ref_exec(tbl[k].ins);
            e = '{tbl[k].lat, tbl[k].skip, tbl[k].we, tbl[k].waddr, tbl[k].wdata,
                  tbl[k].flags, tbl[k].sbyte, tbl[k].cin, 1'b1};
            run_instr(tbl[k].ins, (k == 1) || (k == 5), a, ok);
            if (ok) compare($sformatf("tbl%0d", k), a, e);
        end

        // Reset while EXEC is active abandons the instruction
        instr    = enc(4'hE, 1'b0, 4'd4, 1'b1, 4'd8, 4'd1, 12'h008);
        in_valid = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("rst_mid.done_before", 32'(done), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.flags", 32'(flags), 32'd0);
        chk("rst_mid.rf_we", 32'(rf_we), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rf_we || done) saw = 1'b1;
        end
        chk("rst_mid.quiet", 32'(saw), 32'd0);
        chk("rst_mid.flags_after", 32'(flags), 32'd0);
        mflags = 4'd0;

        for (int k = 0; k < 16; k++) begin
            v = $urandom();
            rf[k]    = v;
            mregs[k] = v;
        end
        for (int n = 0; n < 60; n++) begin
            c = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            i = 1'($urandom_range(0, 1));
            if (i) op2 = 12'($urandom());
            else if ($urandom_range(0, 1) == 1) op2 = {4'($urandom()), 4'b0001, 4'($urandom())};
            else op2 = {5'($urandom()), 3'b000, 4'($urandom())};
            ins = enc(c, i, 4'($urandom()), 1'($urandom()), 4'($urandom()), 4'($urandom()), op2);
            e = ref_exec(ins);
            run_instr(ins, ($urandom_range(0, 3) == 0), a, ok);
            if (ok) compare($sformatf("rnd%0d", n), a, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
